// File: rtl/button_core.sv
// button_core: synchronised, debounced push-button inputs with sticky rising-edge bits and interrupt, on the IO bus
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   io_bus_s_rd_en     - read strobe
//   io_bus_s_wr_en     - write strobe
//   io_bus_s_address   - byte address (chip select by base mask, offset in [7:0])
//   io_bus_s_wr_data   - write data
//   io_bus_s_rd_data   - registered read data, zero outside a selected read
//   btn                - raw asynchronous button levels, active-high
//   irq                - level interrupt, |(edges & irq_en)
module button_core #(
  parameter int          NUM_BUTTONS              = 4,
  parameter int          DEBOUNCE_CYCLES          = 100000,
  parameter logic [31:0] MMIO_BUTTON_BASE_ADDRESS = 32'h0000_4000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   io_bus_s_rd_en,
  input  logic                   io_bus_s_wr_en,
  input  logic [31:0]            io_bus_s_address,
  input  logic [31:0]            io_bus_s_wr_data,
  output logic [31:0]            io_bus_s_rd_data,
  input  logic [NUM_BUTTONS-1:0] btn,
  output logic                   irq
);
  localparam logic [7:0] MMIO_BUTTON_REG_STATE  = 8'h00;
  localparam logic [7:0] MMIO_BUTTON_REG_EDGES  = 8'h04;
  localparam logic [7:0] MMIO_BUTTON_REG_IRQ_EN = 8'h08;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [NUM_BUTTONS-1:0] r_sync1, r_sync2, r_stable, r_edges, r_irq_en;
  logic [NUM_BUTTONS-1:0] w_stable_nxt, w_rise, w_clr;
  logic [CW-1:0]          r_cnt [NUM_BUTTONS];
  logic                   w_cs, w_wr_edges, w_wr_irq_en;
  logic [7:0]             w_off;
  logic [31:0]            w_rd_mux;

  assign w_cs        = (io_bus_s_address & MMIO_BUTTON_BASE_ADDRESS) == MMIO_BUTTON_BASE_ADDRESS;
  assign w_off       = io_bus_s_address[7:0];
  assign w_wr_edges  = w_cs && io_bus_s_wr_en && w_off == MMIO_BUTTON_REG_EDGES;
  assign w_wr_irq_en = w_cs && io_bus_s_wr_en && w_off == MMIO_BUTTON_REG_IRQ_EN;

  // stable flips only once the disagreement has lasted DEBOUNCE_CYCLES cycles
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < NUM_BUTTONS; i++)
      w_stable_nxt[i] = (r_sync2[i] != r_stable[i] && r_cnt[i] == CMAX) ? r_sync2[i] : r_stable[i];
  end

  assign w_rise = w_stable_nxt & ~r_stable;
  assign w_clr  = w_wr_edges ? io_bus_s_wr_data[NUM_BUTTONS-1:0] : '0;
  assign irq    = |(r_edges & r_irq_en);

  always_comb
    w_rd_mux = (w_off == MMIO_BUTTON_REG_STATE)  ? 32'(r_stable) :
               (w_off == MMIO_BUTTON_REG_EDGES)  ? 32'(r_edges)  :
               (w_off == MMIO_BUTTON_REG_IRQ_EN) ? 32'(r_irq_en) : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1          <= '0;
      r_sync2          <= '0;
      r_stable         <= '0;
      r_edges          <= '0;
      r_irq_en         <= '0;
      io_bus_s_rd_data <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1          <= btn;
      r_sync2          <= r_sync1;
      r_stable         <= w_stable_nxt;
      // set has priority over a same-cycle write-1-to-clear
      r_edges          <= (r_edges & ~w_clr) | w_rise;
      io_bus_s_rd_data <= (w_cs && io_bus_s_rd_en) ? w_rd_mux : 32'h0;
      if (w_wr_irq_en) r_irq_en <= io_bus_s_wr_data[NUM_BUTTONS-1:0];
      for (int i = 0; i < NUM_BUTTONS; i++)
        r_cnt[i] <= (r_sync2[i] == r_stable[i] || r_cnt[i] == CMAX) ? '0 : r_cnt[i] + ONE;
    end
  end
endmodule

// File: tb/tb_button_core.sv
// tb_button_core: directed self-checking bench for button_core (NUM_BUTTONS=4, DEBOUNCE_CYCLES=4)
module tb_button_core;
  localparam logic [31:0] BASE   = 32'h0000_4000;
  localparam logic [31:0] STATE  = BASE + 32'h00;
  localparam logic [31:0] EDGES  = BASE + 32'h04;
  localparam logic [31:0] IRQ_EN = BASE + 32'h08;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [3:0]  btn = '0;
  logic        irq;
  logic [31:0] v;
  int          n_tests = 0;
  int          n_fail = 0;

  button_core #(.NUM_BUTTONS(4), .DEBOUNCE_CYCLES(4), .MMIO_BUTTON_BASE_ADDRESS(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_bus_s_rd_en(rd_en), .io_bus_s_wr_en(wr_en),
    .io_bus_s_address(addr), .io_bus_s_wr_data(wdata),
    .io_bus_s_rd_data(rdata), .btn(btn), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    rd_en = 1'b1;
    addr = a;
    tick();
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    rst_n = 1'b1;
    tick(2);
    // reset mid-count with every button held
    wr(IRQ_EN, 32'hF);
    btn = 4'hF;
    tick(2);
    rd(IRQ_EN, v);
    check("pre_reset_irq_en", v, 32'hF);
    rst_n = 1'b0;
    #1;
    check("reset_rd_data", rdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    tick(2);
    #1 rst_n = 1'b1;
    rd(IRQ_EN, v);
    check("reset_irq_en", v, 32'h0);
    rd(EDGES, v);
    check("reset_edges", v, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd(STATE, v);
      check("reset_state_early", v, 32'h0);
    end
    rd(STATE, v);
    check("reset_state_settled", v, 32'hF);
    rd(EDGES, v);
    check("reset_edges_after", v, 32'hF);
    check("reset_irq_disabled", {31'h0, irq}, 32'h0);
    wr(EDGES, 32'hF);
    btn = 4'h0;
    tick(10);
    rd(EDGES, v);
    check("falling_not_captured", v, 32'h0);
    rd(STATE, v);
    check("state_released", v, 32'h0);
    // three-cycle glitch is rejected
    btn[0] = 1'b1;
    tick(3);
    btn[0] = 1'b0;
    tick(8);
    rd(STATE, v);
    check("glitch_state", v, 32'h0);
    rd(EDGES, v);
    check("glitch_edges", v, 32'h0);
    check("glitch_irq", {31'h0, irq}, 32'h0);
    // held press: irq rises exactly at edge k+5
    wr(IRQ_EN, 32'h1);
    btn[0] = 1'b1;
    tick(5);
    check("press_irq_k4", {31'h0, irq}, 32'h0);
    tick();
    check("press_irq_k5", {31'h1 & 31'h0, irq}, 32'h1);
    btn[0] = 1'b0;
    tick(8);
    wr(EDGES, 32'h1);
    check("press_irq_cleared", {31'h0, irq}, 32'h0);
    // edges and masked interrupt
    wr(IRQ_EN, 32'h2);
    btn = 4'b0110;
    tick(8);
    rd(EDGES, v);
    check("edges_two", v, 32'h6);
    check("irq_enabled_edge", {31'h0, irq}, 32'h1);
    rd(STATE, v);
    check("state_two", v, 32'h6);
    wr(EDGES, 32'h2);
    check("irq_after_w1c", {31'h0, irq}, 32'h0);
    rd(EDGES, v);
    check("edges_after_w1c", v, 32'h4);
    btn = 4'h0;
    tick(8);
    wr(EDGES, 32'hF);
    // clear collides with the rising edge of stable[0]
    btn[0] = 1'b1;
    tick(5);
    wr(EDGES, 32'h1);
    rd(EDGES, v);
    check("w1c_collision", v, 32'h1);
    wr(EDGES, 32'h1);
    rd(EDGES, v);
    check("w1c_plain", v, 32'h0);
    btn[0] = 1'b0;
    tick(8);
    // address decode
    rd(BASE + 32'h0C, v);
    check("unmapped_read", v, 32'h0);
    wr(IRQ_EN, 32'h5);
    wr(32'h0000_0008, 32'hF);
    rd(IRQ_EN, v);
    check("no_cs_write_ignored", v, 32'h5);
    rd(32'h0000_0008, v);
    check("no_cs_read", v, 32'h0);
    wr(STATE, 32'hF);
    rd(STATE, v);
    check("state_write_ignored", v, 32'h0);
    wr(IRQ_EN, 32'hFFFF_FFFF);
    rd(IRQ_EN, v);
    check("irq_en_width", v, 32'hF);
    // read timing and read-before-write
    btn = 4'b1001;
    tick(8);
    rd(STATE, v);
    check("read_valid", v, 32'h9);
    tick();
    check("read_one_cycle", rdata, 32'h0);
    rd_en = 1'b1;
    wr_en = 1'b1;
    addr = IRQ_EN;
    wdata = 32'h3;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("rw_old_value", rdata, 32'hF);
    rd(IRQ_EN, v);
    check("rw_new_value", v, 32'h3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/button_core.md
# button_core

Memory-mapped push-button input peripheral on the IO interconnect; it is the read-side counterpart to the LED output core. It synchronises and debounces `NUM_BUTTONS` raw button inputs and latches rising edges in sticky bits. Software reads state and edges over the IO bus, and an interrupt line is asserted for enabled edges.

## Interface
- `NUM_BUTTONS`, default 4: number of button inputs, range 1–32.
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required to accept a level change. Must be at least 1. The counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

Ports:
- `clk` input 1: single clock; all state is on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `io_bus_s_rd_en` input 1: read strobe.
- `io_bus_s_wr_en` input 1: write strobe.
- `io_bus_s_address` input 32: byte address.
- `io_bus_s_wr_data` input 32: write data.
- `io_bus_s_rd_data` output 32: registered read data.
- `btn` input `NUM_BUTTONS`: raw asynchronous button levels, active-high.
- `irq` output 1: level interrupt.

## Operation
- **Chip select:** `cs = (io_bus_s_address & MMIO_BUTTON_BASE_ADDRESS) == MMIO_BUTTON_BASE_ADDRESS`. Offsets are decoded on `io_bus_s_address[7:0]`. New `memory_map.svh` entries are:
  - `MMIO_BUTTON_REG_STATE` = 0x00: read-only, the debounced state.
  - `MMIO_BUTTON_REG_EDGES` = 0x04: read returns the sticky rising-edge bits; write-1-to-clear.
  - `MMIO_BUTTON_REG_IRQ_EN` = 0x08: read/write, the per-button interrupt enable.
- **Unused bits:** bits above `NUM_BUTTONS-1` read as 0, and writes to them are ignored.
- **Synchroniser:** each `btn` bit passes through a 2-flop synchroniser (`sync1` → `sync2`).
- **Debouncer, per button:** each button has a counter `cnt` and a level `stable`.
  - If `sync2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - A single-cycle disagreement therefore resets the accumulation on the next agreeing cycle; a glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `stable`.
- **Edge capture:** `edges[i]` is set on the same clock edge at which `stable[i]` goes 0→1. Falling edges are not captured.
- **Write-1-to-clear:** a write to EDGES with `cs`, `wr_en` and `wr_data[i]=1` clears `edges[i]`. If a set and a clear for the same bit occur in the same cycle, the set wins and the bit stays 1.
- **IRQ_EN write:** `irq_en <= wr_data[NUM_BUTTONS-1:0]`.
- **Ignored writes:** writes to STATE and to unmapped offsets are ignored.
- **Interrupt:** `irq = |(edges & irq_en)`, driven combinationally from registers. It stays high until software clears the edge bits or the enables.
- **Reads:** if `cs && rd_en`, `rd_data <= selected register`, zero-extended. Unmapped offsets return 0. In any cycle without a selected read, `rd_data <= 0`.
- **Simultaneous read and write:** allowed. The read returns the value held before the write.

## Timing
- **Reset values:** on `rst_n` low, immediately and asynchronously, `sync1`, `sync2`, `stable`, `cnt`, `edges`, `irq_en` and `io_bus_s_rd_data` are all 0, and `irq` is 0. A reset mid-debounce discards the partial count, and `stable` restarts at 0.
- **Read latency:** 1 cycle. Data requested at edge N is valid after edge N and held for exactly one cycle.
- **Write latency:** a write takes effect at the strobe edge; `irq` reflects it after that edge.
- **Input-to-state latency:** a `btn` change captured at edge k appears in `sync2` after edge k+1. `stable` and `edges` update at edge k+1+`DEBOUNCE_CYCLES`, provided the level held throughout.
- **Input-to-interrupt latency:** `irq` rises in the same cycle `edges` sets, if enabled.
- **Minimum setting:** with `DEBOUNCE_CYCLES`=1, `stable` follows `sync2` with one cycle of lag.
- **Bus protocol:** no wait states and no backpressure. The bus master must accept `rd_data` the cycle after `rd_en`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `NUM_BUTTONS`=4.
- **Reset:** assert `rst_n`=0 mid-count with `btn`=4'hF. Required: all registers read 0 and `irq`=0. After release with `btn` held, STATE reads 4'hF only after 2+4 cycles.
- **Debounce reject:** toggle `btn[0]` high for 3 cycles, then low. Required: STATE=0, EDGES=0, `irq`=0. Holding high for 4 cycles must give STATE bit0=1 exactly at edge k+5.
- **Edge and interrupt:** write IRQ_EN=4'b0010, then press `btn[1]` and `btn[2]`. Required: EDGES=4'b0110 and `irq`=1. Write EDGES=4'b0010 → `irq`=0 and EDGES=4'b0100.
- **W1C collision:** issue an EDGES write of 4'b0001 in the exact cycle that `stable[0]` rises. Required: EDGES bit0 stays 1.
- **Address decode:** read offset 0x0C → 0. A read with the base address bits not matching → 0, and `irq_en` is unchanged by such a write. A write of 0xFFFF_FFFF to IRQ_EN reads back 0x0000_000F.
- **Read timing:** a `rd_en` pulse on STATE gives `rd_data` valid for exactly one cycle; it is 0 the following cycle.
